// File: rtl/ensemble_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ensemble_pkg                                               |
// | Description : Shared constants and types for the ensemble majority vote. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ensemble_pkg;

    localparam int NUM_CLASSIFIERS = 3;

    // Classifier slot assignment on the vote inputs
    localparam int GNB = 0;
    localparam int LR  = 1;
    localparam int GB  = 2;

    // Status flag positions in the result word
    localparam int FLAG_UNANIMOUS = 16;
    localparam int FLAG_TIE       = 17;
    localparam int FLAG_MISMATCH  = 18;

    typedef struct packed {
        logic mismatch;
        logic tie;
        logic unanimous;
    } vote_flags_t;

endpackage : ensemble_pkg
`default_nettype wire

// File: rtl/vote_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vote_fifo                                                  |
// | Description : Synchronous FIFO with occupancy count, first-word          |
// |               fall-through read port.                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vote_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int               c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]    c_depth = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    // Overflow/underflow requests are dropped rather than corrupting state
    assign w_wr = i_push && (r_count != c_depth);
    assign w_rd = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : vote_fifo
`default_nettype wire

// File: rtl/ensemble_vote.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ensemble_vote                                              |
// | Description : Buffers three classifier result streams and emits one      |
// |               majority-voted label with status flags per triple.         |
// |               Define ENSEMBLE_VOTE_STATS_EN for saturating statistics.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ensemble_vote
    import ensemble_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = 4,
    parameter int CLASS_WIDTH = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIE_SEL     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
    input  logic                  s_axis_tvalid_0,
    input  logic                  s_axis_tlast_0,
    output logic                  s_axis_tready_0,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
    input  logic                  s_axis_tvalid_1,
    input  logic                  s_axis_tlast_1,
    output logic                  s_axis_tready_1,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
    input  logic                  s_axis_tvalid_2,
    input  logic                  s_axis_tlast_2,
    output logic                  s_axis_tready_2,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
`ifdef ENSEMBLE_VOTE_STATS_EN
    ,
    output logic [31:0]           stat_votes,
    output logic [31:0]           stat_ties,
    output logic [31:0]           stat_mismatch
`endif
);

    localparam int                 c_entry_w = CLASS_WIDTH + 1;
    localparam int                 c_cnt_w   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(FIFO_DEPTH);
    localparam logic [1:0]         c_tie_idx = 2'(TIE_SEL);

    logic [DATA_WIDTH-1:0]      w_in_data  [NUM_CLASSIFIERS];
    logic [NUM_CLASSIFIERS-1:0] w_in_valid;
    logic [NUM_CLASSIFIERS-1:0] w_in_last;
    logic [NUM_CLASSIFIERS-1:0] w_ready;
    logic [NUM_CLASSIFIERS-1:0] w_nonempty;
    logic [c_entry_w-1:0]       w_head     [NUM_CLASSIFIERS];
    logic [c_cnt_w-1:0]         w_count    [NUM_CLASSIFIERS];
    logic [CLASS_WIDTH-1:0]     w_lab      [NUM_CLASSIFIERS];
    logic [NUM_CLASSIFIERS-1:0] w_lasts;
    logic [CLASS_WIDTH-1:0]     w_label;
    vote_flags_t                w_flags;
    logic [DATA_WIDTH-1:0]      w_result;
    logic                       w_fire;
    logic                       w_unused;

    logic [DATA_WIDTH-1:0]      r_tdata;
    logic                       r_tlast;
    logic                       r_valid;

    assign w_in_data[GNB] = s_axis_tdata_0;
    assign w_in_data[LR]  = s_axis_tdata_1;
    assign w_in_data[GB]  = s_axis_tdata_2;
    assign w_in_valid     = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
    assign w_in_last      = {s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};

    assign s_axis_tready_0 = w_ready[GNB];
    assign s_axis_tready_1 = w_ready[LR];
    assign s_axis_tready_2 = w_ready[GB];

    // tkeep and the upper tdata bits carry nothing the vote needs
    assign w_unused = ^{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
                        s_axis_tdata_0[DATA_WIDTH-1:CLASS_WIDTH],
                        s_axis_tdata_1[DATA_WIDTH-1:CLASS_WIDTH],
                        s_axis_tdata_2[DATA_WIDTH-1:CLASS_WIDTH]};

    for (genvar g = 0; g < NUM_CLASSIFIERS; g++) begin : g_fifo
        // Ready comes only from registered occupancy, never from m_axis_tready
        assign w_ready[g]    = !rst && (w_count[g] != c_depth);
        assign w_nonempty[g] = (w_count[g] != '0);
        assign w_lab[g]      = w_head[g][CLASS_WIDTH-1:0];
        assign w_lasts[g]    = w_head[g][CLASS_WIDTH];

        vote_fifo #(
            .WIDTH (c_entry_w),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_in_valid[g] && w_ready[g]),
            .i_data  ({w_in_last[g], w_in_data[g][CLASS_WIDTH-1:0]}),
            .i_pop   (w_fire),
            .o_data  (w_head[g]),
            .o_count (w_count[g])
        );
    end

    assign w_fire = (&w_nonempty) && (!r_valid || m_axis_tready);

    always_comb begin
        w_flags           = '0;
        w_label           = w_lab[c_tie_idx];
        if ((w_lab[GNB] == w_lab[LR]) || (w_lab[GNB] == w_lab[GB])) begin
            w_label = w_lab[GNB];
        end else if (w_lab[LR] == w_lab[GB]) begin
            w_label = w_lab[LR];
        end else begin
            w_flags.tie = 1'b1;
        end
        w_flags.unanimous = (w_lab[GNB] == w_lab[LR]) && (w_lab[LR] == w_lab[GB]);
        w_flags.mismatch  = !((&w_lasts) || !(|w_lasts));
    end

    always_comb begin
        w_result                    = '0;
        w_result[CLASS_WIDTH-1:0]   = w_label;
        w_result[FLAG_UNANIMOUS]    = w_flags.unanimous;
        w_result[FLAG_TIE]          = w_flags.tie;
        w_result[FLAG_MISMATCH]     = w_flags.mismatch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tdata <= '0;
            r_tlast <= 1'b0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_tdata <= w_result;
            r_tlast <= w_lasts[GNB];
        end else if (m_axis_tready) begin
            r_valid <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tvalid = r_valid;
    assign m_axis_tkeep  = {KEEP_WIDTH{r_valid}};

`ifdef ENSEMBLE_VOTE_STATS_EN
    logic [31:0] r_votes;
    logic [31:0] r_ties;
    logic [31:0] r_mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_votes    <= '0;
            r_ties     <= '0;
            r_mismatch <= '0;
        end else if (w_fire) begin
            if (r_votes != '1) begin
                r_votes <= r_votes + 1'b1;
            end
            if (w_flags.tie && (r_ties != '1)) begin
                r_ties <= r_ties + 1'b1;
            end
            if (w_flags.mismatch && (r_mismatch != '1)) begin
                r_mismatch <= r_mismatch + 1'b1;
            end
        end
    end

    assign stat_votes    = r_votes;
    assign stat_ties     = r_ties;
    assign stat_mismatch = r_mismatch;
`endif

endmodule : ensemble_vote
`default_nettype wire

// File: tb/tb_ensemble_vote.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ensemble_vote                                           |
// | Description : Directed and random self-checking bench for ensemble_vote  |
// |               against a queue-based majority-vote reference model.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ensemble_vote;

    localparam int TIE_SEL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data [3];
    logic [3:0]  s_keep [3];
    logic [2:0]  s_vld;
    logic [2:0]  s_last;
    logic [2:0]  s_rdy;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
`ifdef ENSEMBLE_VOTE_STATS_EN
    logic [31:0] stat_votes;
    logic [31:0] stat_ties;
    logic [31:0] stat_mismatch;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    int          exp_votes = 0;
    int          exp_ties  = 0;
    int          exp_mm    = 0;
    logic [2:0]  acc;
    logic [8:0]  q0 [$];
    logic [8:0]  q1 [$];
    logic [8:0]  q2 [$];

    always #5 clk = ~clk;

    ensemble_vote #(
        .DATA_WIDTH  (32),
        .KEEP_WIDTH  (4),
        .CLASS_WIDTH (8),
        .FIFO_DEPTH  (4),
        .TIE_SEL     (TIE_SEL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tdata_0  (s_data[0]),
        .s_axis_tkeep_0  (s_keep[0]),
        .s_axis_tvalid_0 (s_vld[0]),
        .s_axis_tlast_0  (s_last[0]),
        .s_axis_tready_0 (s_rdy[0]),
        .s_axis_tdata_1  (s_data[1]),
        .s_axis_tkeep_1  (s_keep[1]),
        .s_axis_tvalid_1 (s_vld[1]),
        .s_axis_tlast_1  (s_last[1]),
        .s_axis_tready_1 (s_rdy[1]),
        .s_axis_tdata_2  (s_data[2]),
        .s_axis_tkeep_2  (s_keep[2]),
        .s_axis_tvalid_2 (s_vld[2]),
        .s_axis_tlast_2  (s_last[2]),
        .s_axis_tready_2 (s_rdy[2]),
        .m_axis_tdata    (m_data),
        .m_axis_tkeep    (m_keep),
        .m_axis_tvalid   (m_valid),
        .m_axis_tlast    (m_last),
        .m_axis_tready   (m_ready)
`ifdef ENSEMBLE_VOTE_STATS_EN
        ,
        .stat_votes      (stat_votes),
        .stat_ties       (stat_ties),
        .stat_mismatch   (stat_mismatch)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference vote: count how many inputs share each label
    function automatic logic [31:0] ref_vote(input logic [8:0] e0, input logic [8:0] e1,
                                             input logic [8:0] e2, output bit tie, output bit mm);
        logic [7:0]  lab [3];
        logic [31:0] r;
        int          votes;
        bit          found;
        lab[0] = e0[7:0];
        lab[1] = e1[7:0];
        lab[2] = e2[7:0];
        r      = '0;
        found  = 1'b0;
        tie    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            votes = 0;
            for (int j = 0; j < 3; j++) begin
                if (lab[i] == lab[j]) votes++;
            end
            if (!found && votes >= 2) begin
                found   = 1'b1;
                r[7:0]  = lab[i];
                r[16]   = (votes == 3);
            end
        end
        if (!found) begin
            tie    = 1'b1;
            r[7:0] = lab[TIE_SEL];
            r[17]  = 1'b1;
        end
        mm    = ((int'(e0[8]) + int'(e1[8]) + int'(e2[8])) % 3) != 0;
        r[18] = mm;
        return r;
    endfunction

    task automatic check_out();
        logic [8:0]  e0, e1, e2;
        logic [31:0] exp;
        bit          tie, mm;
        logic        have;
        have = (q0.size() > 0) && (q1.size() > 0) && (q2.size() > 0);
        check("out_pending", have, 1'b1);
        if (have) begin
            e0  = q0.pop_front();
            e1  = q1.pop_front();
            e2  = q2.pop_front();
            exp = ref_vote(e0, e1, e2, tie, mm);
            check("out_tdata", m_data, exp);
            check("out_tlast", m_last, e0[8]);
            check("out_tkeep", m_keep, 4'hf);
            exp_votes++;
            if (tie) exp_ties++;
            if (mm)  exp_mm++;
        end
        n_out++;
    endtask

    // One clock: record handshakes seen before the edge, then step past it
    task automatic tick();
        @(negedge clk);
        acc = s_vld & s_rdy;
        if (acc[0]) q0.push_back({s_last[0], s_data[0][7:0]});
        if (acc[1]) q1.push_back({s_last[1], s_data[1][7:0]});
        if (acc[2]) q2.push_back({s_last[2], s_data[2][7:0]});
        if (m_valid && m_ready) check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int i, input logic [7:0] label, input logic last);
        s_data[i]      = $urandom;
        s_data[i][7:0] = label;
        s_keep[i]      = 4'($urandom);
        s_last[i]      = last;
    endtask

    task automatic send3(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                         input logic [2:0] t, input logic [31:0] exp_word, input string tag);
        set_beat(0, l0, t[0]);
        set_beat(1, l1, t[1]);
        set_beat(2, l2, t[2]);
        s_vld = 3'b111;
        tick();
        s_vld = 3'b000;
        check({tag, "_early"}, m_valid, 1'b0);
        tick();
        check({tag, "_valid"}, m_valid, 1'b1);
        check({tag, "_tdata"}, m_data, exp_word);
        check({tag, "_tlast"}, m_last, t[0]);
        tick();
    endtask

    task automatic check_stats();
`ifdef ENSEMBLE_VOTE_STATS_EN
        check("stat_votes", stat_votes, exp_votes);
        check("stat_ties", stat_ties, exp_ties);
        check("stat_mismatch", stat_mismatch, exp_mm);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          base;
        int          qmin;
        logic [31:0] hold;

        rst     = 1'b1;
        s_vld   = 3'b000;
        s_last  = 3'b000;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) set_beat(i, 8'h00, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", m_valid, 1'b0);
        check("rst_tdata", m_data, 32'h0);
        check("rst_tlast", m_last, 1'b0);
        check("rst_tkeep", m_keep, 4'h0);
        check("rst_tready", s_rdy, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rdy_after_rst", s_rdy, 3'b111);
        @(posedge clk);
        #1;

        // Directed vote patterns
        send3(8'd3, 8'd3, 8'd3, 3'b000, 32'h0001_0003, "unanimous");
        send3(8'd5, 8'd7, 8'd5, 3'b000, 32'h0000_0005, "maj_ac");
        send3(8'd1, 8'd2, 8'd2, 3'b000, 32'h0000_0002, "maj_bc");
        send3(8'd4, 8'd6, 8'd9, 3'b000, 32'h0002_0009, "tie");
        send3(8'd2, 8'd2, 8'd2, 3'b101, 32'h0005_0002, "last_mm");
        check_stats();

        // Stream 0 fills while its partners are idle
        base  = n_out;
        s_vld = 3'b001;
        for (int k = 0; k < 4; k++) begin
            set_beat(0, 8'(10 + k), 1'b0);
            tick();
        end
        set_beat(0, 8'd14, 1'b0);
        check("full_rdy0", s_rdy[0], 1'b0);
        tick();
        tick();
        check("partial_no_out", m_valid, 1'b0);
        check("full_rdy0_hold", s_rdy[0], 1'b0);
        s_vld = 3'b111;
        for (int k = 0; k < 4; k++) begin
            set_beat(1, 8'($urandom_range(10, 14)), 1'b0);
            set_beat(2, 8'($urandom_range(10, 14)), 1'b0);
            tick();
            if (acc[0]) s_vld[0] = 1'b0;
        end
        s_vld = 3'b000;
        repeat (4) tick();
        check("four_results", n_out - base, 4);
        check("rdy0_back", s_rdy[0], 1'b1);
        set_beat(1, 8'd14, 1'b0);
        set_beat(2, 8'd14, 1'b0);
        s_vld = 3'b110;
        tick();
        s_vld = 3'b000;
        repeat (3) tick();
        check("flush_leftover", n_out - base, 5);

        // Downstream stall with every buffer full
        m_ready = 1'b0;
        base    = n_out;
        s_vld   = 3'b111;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 3; i++) set_beat(i, 8'($urandom_range(0, 7)), 1'($urandom));
            tick();
        end
        s_vld = 3'b000;
        check("all_full", s_rdy, 3'b000);
        check("hold_valid", m_valid, 1'b1);
        hold = m_data;
        repeat (10) begin
            tick();
            check("hold_stable", m_data, hold);
        end
        m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("b2b_valid", m_valid, 1'b1);
            tick();
        end
        check("b2b_done", m_valid, 1'b0);
        check("b2b_count", n_out - base, 5);

        // Reset with partial entries queued
        s_vld = 3'b011;
        for (int k = 0; k < 2; k++) begin
            set_beat(0, 8'd33, 1'b0);
            set_beat(1, 8'd44, 1'b0);
            tick();
        end
        s_vld = 3'b000;
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_tvalid", m_valid, 1'b0);
        check("mid_rst_tready", s_rdy, 3'b000);
        check("mid_rst_tdata", m_data, 32'h0);
        q0.delete();
        q1.delete();
        q2.delete();
        exp_votes = 0;
        exp_ties  = 0;
        exp_mm    = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_tready", s_rdy, 3'b111);
        base = n_out;
        send3(8'd8, 8'd8, 8'd1, 3'b000, 32'h0000_0008, "post_rst");
        repeat (3) tick();
        check("single_out", n_out - base, 1);

        // Random traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!s_vld[i] || acc[i]) begin
                    s_vld[i] = ($urandom_range(0, 9) < 6);
                    set_beat(i, 8'($urandom_range(0, 3)), 1'($urandom));
                end
            end
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        s_vld   = 3'b000;
        m_ready = 1'b1;
        repeat (10) tick();
        check("drain_idle", m_valid, 1'b0);
        qmin = q0.size();
        if (q1.size() < qmin) qmin = q1.size();
        if (q2.size() < qmin) qmin = q2.size();
        check("drain_queues", qmin, 0);
        check_stats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ensemble_vote
`default_nettype wire

// File: doc/ensemble_vote.md
# ensemble_vote

Majority-vote combiner that sits directly downstream of the three-classifier ensemble (Gaussian NB, logistic regression, gradient boost). It consumes the three classifier AXI-Stream result streams and buffers each in a small FIFO. When one result is available from every classifier, it pops all three together and emits a single voted label with status flags on one AXI-Stream master.

## Interface
- DATA_WIDTH, 32, tdata width of all streams
- KEEP_WIDTH, 4, tkeep width of all streams
- CLASS_WIDTH, 8, label width, taken from tdata[CLASS_WIDTH-1:0]
- FIFO_DEPTH, 4, entries per input FIFO (power of two, ≥2)
- TIE_SEL, 2, classifier index whose label wins when all three disagree
- clk  in  1  clock; one clock; reset is asynchronous and active-high
- rst  in  1  asynchronous active-high reset
- s_axis_tdata_i / tkeep_i / tvalid_i / tlast_i  in  DATA_WIDTH / KEEP_WIDTH / 1 / 1  result stream from classifier i (i = 0,1,2); tkeep is ignored
- s_axis_tready_i  out  1  FIFO i not full
- m_axis_tdata  out  DATA_WIDTH  [CLASS_WIDTH-1:0] voted label, [16] unanimous, [17] tie, [18] tlast mismatch, all other bits 0
- m_axis_tkeep  out  KEEP_WIDTH  all ones while valid
- m_axis_tvalid / m_axis_tlast  out  1  result valid / frame end
- m_axis_tready  in  1  downstream ready
- stat_votes / stat_ties / stat_mismatch  out  32 each  present only with ENSEMBLE_VOTE_STATS_EN

## Operation
- Per input: FIFO entry {tlast, label}. A push occurs when tvalid_i && tready_i. tready_i = (count_i != FIFO_DEPTH) and depends only on the registered count. When full, tready_i is low even in a pop cycle.
- fire = all three FIFOs non-empty && (!m_axis_tvalid || m_axis_tready). On fire, all three FIFOs are popped in the same cycle and the output register is loaded.
- Vote on labels a, b, c:
  - if a==b or a==c, the label is a;
  - else if b==c, the label is b;
  - else the label is the one from TIE_SEL and tie=1.
  - unanimous = (a==b && b==c).
- tlast: m_axis_tlast = tlast_0. mismatch = the three tlasts are not all equal.
- The output register holds data while m_axis_tvalid && !m_axis_tready. m_axis_tvalid drops after a handshake unless fire occurs in the same cycle (back-to-back).
- Simultaneous push and pop on a FIFO: the count is unchanged and the data order is preserved.
- Pointers wrap modulo FIFO_DEPTH. The count has log2(FIFO_DEPTH)+1 bits.
- Reset (any time, including mid-frame):
  - FIFOs empty;
  - all tready low while rst is high;
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tkeep=0;
  - counters 0.
- After reset release, all tready are high from the first cycle.

## Timing
- Input handshake at edge E writes the FIFO at E. fire can occur at E+1, so m_axis_tvalid is high after E+1. Latency from the last of the three arrivals to valid is 1 cycle.
- Throughput is one vote per cycle with m_axis_tready held high.
- There is no combinational path from m_axis_tready to any s_axis_tready_i.

## Configuration
- ENSEMBLE_VOTE_STATS_EN defined:
  - the three stat ports exist;
  - stat_votes increments on every fire;
  - stat_ties increments on fire with tie=1;
  - stat_mismatch increments on fire with mismatch=1;
  - all three saturate at 0xFFFF_FFFF.
- Not defined: the ports and counters are absent and voting behaviour is identical.

## Structure
- Package ensemble_pkg holds:
  - NUM_CLASSIFIERS=3;
  - classifier index constants (GNB=0, LR=1, GB=2);
  - flag bit positions (FLAG_UNANIMOUS=16, FLAG_TIE=17, FLAG_MISMATCH=18).
- Sub-module vote_fifo (synchronous, parameterised width/depth, count output) is instantiated three times.
- The vote logic and output register live in the top module.

## Test plan
- Labels 3,3,3 on all inputs, m_axis_tready=1 → tdata=0x0001_0003, tvalid high 1 cycle after the last arrival.
- Labels 5,7,5 → label 5, flags 0. Labels 1,2,2 → label 2, flags 0. Labels 4,6,9 with TIE_SEL=2 → tdata=0x0002_0009.
- tlast 1,0,1 with labels 2,2,2 → tdata=0x0005_0002, m_axis_tlast=1; with STATS_EN, stat_mismatch=1.
- Stream 0 sends 5 beats, streams 1 and 2 stay idle, FIFO_DEPTH=4 → s_axis_tready_0 low after the 4th beat and no output. Streams 1 and 2 then send 4 beats → 4 results in order, and tready_0 returns high.
- m_axis_tready held low for 10 cycles with full FIFOs → tdata stable and no loss. Release → 5 results back-to-back, one per cycle.
- Assert rst mid-stream with 2 entries queued → tvalid=0 and tready=0 during reset. After release, new labels 8,8,1 → a single output of label 8 and no stale data.
